// File: rtl/oserdes_sched_pkg.sv
// Shared types, defaults and helpers for the OSERDES trigger scheduler.
package oserdes_sched_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_GAP_WORDS = 2;
  localparam int unsigned DEF_NREQ      = 4;
  localparam int unsigned DEF_PW_BITS   = 8;

  // Widest word the thermometer helper can build.
  localparam int unsigned THERM_MAX = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Top n bits of a width-bit word set (MSB-first pulse head), result right-aligned.
  function automatic logic [THERM_MAX-1:0] therm_msb(input int unsigned n,
                                                     input int unsigned width);
    logic [THERM_MAX-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < THERM_MAX; i++) begin
      if ((i < width) && ((i + n) >= width)) t[i] = 1'b1;
    end
    return t;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after i_last, cyclic.
module rr_arbiter #(
  parameter  int unsigned NREQ  = 4,
  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [NREQ-1:0]  o_gnt,
  output logic [IDX_W-1:0] o_index
);

  logic        w_found;
  int unsigned w_cand;

  // Scan the requesters starting one past the last winner.
  always_comb begin
    o_gnt   = '0;
    o_index = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_cand = (32'(i_last) + k) % NREQ;
      if (!w_found && i_req[IDX_W'(w_cand)]) begin
        w_found                = 1'b1;
        o_gnt[IDX_W'(w_cand)] = 1'b1;
        o_index                = IDX_W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/oserdes_trigger_scheduler.sv
// Arbitrates trigger requests and turns each pulse width into MSB-first serializer words.
module oserdes_trigger_scheduler
  import oserdes_sched_pkg::*;
#(
  parameter  int unsigned WIDTH     = DEF_WIDTH,
  parameter  int unsigned NREQ      = DEF_NREQ,
  parameter  int unsigned PW_BITS   = DEF_PW_BITS,
  parameter  int unsigned GAP_WORDS = DEF_GAP_WORDS,
  localparam int unsigned IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ*PW_BITS-1:0] i_pulse_width,
  output logic [NREQ-1:0]         o_ack,
  output logic [WIDTH-1:0]        o_word,
  output logic                    o_busy,
  output logic [IDX_W-1:0]        o_owner,
  output logic [15:0]             o_pulse_count,
  output logic [7:0]              o_abort_count
);

  localparam int unsigned GAP_W    = (GAP_WORDS > 1) ? $clog2(GAP_WORDS) : 1;
  localparam int unsigned GAP_LOAD = (GAP_WORDS > 0) ? GAP_WORDS - 1 : 0;

  state_t             r_state,        w_nxt_state;
  logic [PW_BITS-1:0] r_remaining,    w_nxt_remaining;
  logic [GAP_W-1:0]   r_gap_cnt,      w_nxt_gap_cnt;
  logic [WIDTH-1:0]   r_word,         w_nxt_word;
  logic [NREQ-1:0]    r_ack,          w_nxt_ack;
  logic               r_busy;
  logic [IDX_W-1:0]   r_owner,        w_nxt_owner;
  logic [IDX_W-1:0]   r_last,         w_nxt_last;
  logic [15:0]        r_pulse_count,  w_nxt_pulse_count;
  logic [7:0]         r_abort_count,  w_nxt_abort_count;

  logic [NREQ-1:0]    w_gnt;
  logic [IDX_W-1:0]   w_idx;
  logic [PW_BITS-1:0] w_pw;
  logic [PW_BITS-1:0] w_src;
  logic               w_src_last;
  logic [WIDTH-1:0]   w_therm;
  logic               w_load;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .i_req   (i_req),
    .i_last  (r_last),
    .o_gnt   (w_gnt),
    .o_index (w_idx)
  );

  // Word source: the granted width in IDLE, otherwise the bits still owed.
  always_comb begin
    w_pw       = i_pulse_width[32'(w_idx) * PW_BITS +: PW_BITS];
    w_src      = (r_state == IDLE) ? w_pw : r_remaining;
    w_src_last = (32'(w_src) <= WIDTH);
    w_therm    = WIDTH'(therm_msb(32'(w_src), WIDTH));
  end

  // Next-state and next-output decode; w_load emits the next chunk of w_src.
  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_remaining   = r_remaining;
    w_nxt_gap_cnt     = r_gap_cnt;
    w_nxt_word        = '0;
    w_nxt_ack         = '0;
    w_nxt_owner       = r_owner;
    w_nxt_last        = r_last;
    w_nxt_pulse_count = r_pulse_count;
    w_nxt_abort_count = r_abort_count;
    w_load            = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_enable && (|i_req)) begin
          w_nxt_ack   = w_gnt;
          w_nxt_owner = w_idx;
          w_nxt_last  = w_idx;
          if (w_pw != '0) begin
            w_nxt_state = EMIT;
            w_load      = 1'b1;
          end
        end
      end
      EMIT: begin
        if (r_remaining == '0) begin
          if (GAP_WORDS == 0) begin
            w_nxt_state = IDLE;
          end else begin
            w_nxt_state   = GAP;
            w_nxt_gap_cnt = GAP_W'(GAP_LOAD);
          end
        end else if (!i_enable) begin
          w_nxt_state     = IDLE;
          w_nxt_remaining = '0;
          if (r_abort_count != 8'hFF) w_nxt_abort_count = r_abort_count + 8'd1;
        end else begin
          w_load = 1'b1;
        end
      end
      GAP: begin
        if (r_gap_cnt == '0) begin
          w_nxt_state = IDLE;
        end else begin
          w_nxt_gap_cnt = r_gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        w_nxt_state = IDLE;
      end
    endcase

    if (w_load) begin
      if (w_src_last) begin
        w_nxt_word        = w_therm;
        w_nxt_remaining   = '0;
        w_nxt_pulse_count = r_pulse_count + 16'd1;
      end else begin
        w_nxt_word      = '1;
        w_nxt_remaining = w_src - PW_BITS'(WIDTH);
      end
    end
  end

  // State and registered outputs; reset clears the word immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_remaining   <= '0;
      r_gap_cnt     <= '0;
      r_word        <= '0;
      r_ack         <= '0;
      r_busy        <= 1'b0;
      r_owner       <= '0;
      r_last        <= IDX_W'(NREQ - 1);
      r_pulse_count <= '0;
      r_abort_count <= '0;
    end else begin
      r_state       <= w_nxt_state;
      r_remaining   <= w_nxt_remaining;
      r_gap_cnt     <= w_nxt_gap_cnt;
      r_word        <= w_nxt_word;
      r_ack         <= w_nxt_ack;
      r_busy        <= (w_nxt_state != IDLE);
      r_owner       <= w_nxt_owner;
      r_last        <= w_nxt_last;
      r_pulse_count <= w_nxt_pulse_count;
      r_abort_count <= w_nxt_abort_count;
    end
  end

  assign o_ack         = r_ack;
  assign o_word        = r_word;
  assign o_busy        = r_busy;
  assign o_owner       = r_owner;
  assign o_pulse_count = r_pulse_count;
  assign o_abort_count = r_abort_count;

endmodule

// File: tb/tb_oserdes_trigger_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a word-queue model.
module tb_oserdes_trigger_scheduler;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned NREQ      = 4;
  localparam int unsigned PW_BITS   = 8;
  localparam int unsigned GAP_WORDS = 2;

  // kind: 0 = gap word, 1 = pulse word with more to follow, 2 = last pulse word
  typedef struct {
    logic [7:0] w;
    int         kind;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [3:0]  rq;
  logic [7:0]  rpw [4];
  logic [31:0] pw_bus;

  logic [3:0]  o_ack;
  logic [7:0]  o_word;
  logic        o_busy;
  logic [1:0]  o_owner;
  logic [15:0] o_pulse_count;
  logic [7:0]  o_abort_count;

  int n_checks = 0;
  int n_errors = 0;

  item_t       m_q[$];
  int          m_last;
  logic [1:0]  m_owner;
  logic        m_busy;
  logic        m_nf;
  logic [15:0] m_pcnt;
  logic [7:0]  m_acnt;
  int          busy_cycles;

  always #5 clk = ~clk;

  always_comb pw_bus = {rpw[3], rpw[2], rpw[1], rpw[0]};

  oserdes_trigger_scheduler #(
    .WIDTH     (WIDTH),
    .NREQ      (NREQ),
    .PW_BITS   (PW_BITS),
    .GAP_WORDS (GAP_WORDS)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_enable      (enable),
    .i_req         (rq),
    .i_pulse_width (pw_bus),
    .o_ack         (o_ack),
    .o_word        (o_word),
    .o_busy        (o_busy),
    .o_owner       (o_owner),
    .o_pulse_count (o_pulse_count),
    .o_abort_count (o_abort_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_last  = -1;
    m_owner = '0;
    m_busy  = 1'b0;
    m_nf    = 1'b0;
    m_pcnt  = '0;
    m_acnt  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rq    = '0;
    #1;
    chk("rst_word",  32'(o_word), 32'd0);
    chk("rst_ack",   32'(o_ack), 32'd0);
    chk("rst_busy",  32'(o_busy), 32'd0);
    chk("rst_owner", 32'(o_owner), 32'd0);
    chk("rst_pcnt",  32'(o_pulse_count), 32'd0);
    chk("rst_acnt",  32'(o_abort_count), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Predict the next registered outputs, clock once, compare, retire acked requests.
  task automatic step();
    logic [3:0] ea;
    logic [7:0] ew;
    logic       eb;
    item_t      it;
    int         c;
    int         w;
    int         m;
    ea = '0;
    ew = '0;
    eb = 1'b0;
    if (m_nf && !enable) begin
      m_q.delete();
      m_nf = 1'b0;
      if (m_acnt != 8'hFF) m_acnt++;
    end else if (m_q.size() > 0) begin
      it   = m_q.pop_front();
      ew   = it.w;
      eb   = 1'b1;
      m_nf = (it.kind == 1);
      if (it.kind == 2) m_pcnt++;
    end else if (!m_busy && enable && (rq != '0)) begin
      c = 0;
      for (int k = NREQ; k >= 1; k--) begin
        if (rq[(m_last + k) % NREQ]) c = (m_last + k) % NREQ;
      end
      ea[c]   = 1'b1;
      m_last  = c;
      m_owner = 2'(c);
      w = int'(rpw[c]);
      if (w > 0) begin
        while (w > 0) begin
          m    = (w > 8) ? 8 : w;
          it.w = 8'(((1 << m) - 1) << (8 - m));
          it.kind = (w <= 8) ? 2 : 1;
          m_q.push_back(it);
          w -= 8;
        end
        for (int g = 0; g < int'(GAP_WORDS); g++) begin
          it.w    = 8'h00;
          it.kind = 0;
          m_q.push_back(it);
        end
        it   = m_q.pop_front();
        ew   = it.w;
        eb   = 1'b1;
        m_nf = (it.kind == 1);
        if (it.kind == 2) m_pcnt++;
      end
    end else begin
      m_nf = 1'b0;
    end
    m_busy = eb;

    @(posedge clk);
    #1;
    chk("ack",   32'(o_ack), 32'(ea));
    chk("word",  32'(o_word), 32'(ew));
    chk("busy",  32'(o_busy), 32'(eb));
    chk("owner", 32'(o_owner), 32'(m_owner));
    chk("pcnt",  32'(o_pulse_count), 32'(m_pcnt));
    chk("acnt",  32'(o_abort_count), 32'(m_acnt));
    for (int i = 0; i < 4; i++) if (ea[i]) rq[i] = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b1;
    enable = 1'b1;
    rq     = '0;
    for (int i = 0; i < 4; i++) rpw[i] = '0;
    model_reset();
    #2;
    do_reset();

    // Short pulse: one thermometer word then the gap.
    rpw[0] = 8'd3; rq[0] = 1'b1;
    step();
    chk("t1_ack",  32'(o_ack), 32'h1);
    chk("t1_word", 32'(o_word), 32'hE0);
    step(); chk("t1_gap0", 32'(o_word), 32'h00);
    step(); chk("t1_gap1", 32'(o_busy), 32'h1);
    step(); chk("t1_idle", 32'(o_busy), 32'h0);
    chk("t1_pcnt", 32'(o_pulse_count), 32'd1);

    // Multi-word pulse.
    rpw[1] = 8'd20; rq[1] = 1'b1;
    busy_cycles = 0;
    step(); chk("t2_w0", 32'(o_word), 32'hFF); busy_cycles += int'(o_busy);
    step(); chk("t2_w1", 32'(o_word), 32'hFF); busy_cycles += int'(o_busy);
    step(); chk("t2_w2", 32'(o_word), 32'hF0); busy_cycles += int'(o_busy);
    for (int i = 0; i < 3; i++) begin step(); busy_cycles += int'(o_busy); end
    chk("t2_busy_cycles", 32'(busy_cycles), 32'd5);

    // Round-robin order from a fresh pointer.
    do_reset();
    rq = 4'b1111;
    for (int i = 0; i < 4; i++) rpw[i] = 8'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_owner", 32'(o_owner), 32'(i));
    end
    rq = 4'b0101;
    step(); chk("rr_wrap0", 32'(o_owner), 32'd0);
    step(); chk("rr_wrap2", 32'(o_owner), 32'd2);

    // Zero-width grant: ack only.
    rq[2] = 1'b1;
    step();
    chk("w0_ack",  32'(o_ack), 32'h4);
    chk("w0_word", 32'(o_word), 32'h0);
    chk("w0_busy", 32'(o_busy), 32'h0);
    chk("w0_pcnt", 32'(o_pulse_count), 32'd0);

    // Abort by dropping enable after the second word.
    rpw[1] = 8'd40; rq[1] = 1'b1;
    step(); chk("ab_w0", 32'(o_word), 32'hFF);
    step(); chk("ab_w1", 32'(o_word), 32'hFF);
    enable = 1'b0;
    step();
    chk("ab_w2",   32'(o_word), 32'h00);
    chk("ab_busy", 32'(o_busy), 32'h0);
    chk("ab_acnt", 32'(o_abort_count), 32'd1);
    chk("ab_pcnt", 32'(o_pulse_count), 32'd0);
    enable = 1'b1;
    step();

    // Reset in the middle of a burst, then a fresh grant goes to requester 0.
    rpw[3] = 8'd100; rq[3] = 1'b1;
    step(); step();
    do_reset();
    rpw[0] = 8'd5; rpw[3] = 8'd5; rq = 4'b1001;
    step();
    chk("rs_ack",  32'(o_ack), 32'h1);
    chk("rs_word", 32'(o_word), 32'hF8);

    // Random traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      enable = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < 4; i++) begin
        if (!rq[i] && ($urandom_range(0, 3) == 0)) begin
          case ($urandom_range(0, 9))
            0:             rpw[i] = 8'd0;
            1, 2, 3, 4:    rpw[i] = 8'($urandom_range(1, 8));
            5, 6, 7:       rpw[i] = 8'($urandom_range(9, 40));
            default:       rpw[i] = 8'($urandom_range(41, 255));
          endcase
          rq[i] = 1'b1;
        end
      end
      step();
    end

    enable = 1'b1;
    rq     = '0;
    for (int i = 0; i < 40; i++) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/oserdes_trigger_scheduler.md
# oserdes_trigger_scheduler

Shares the single serialized trigger output between several requesters. It arbitrates round-robin among NREQ trigger requests and converts each granted pulse width (in serial bit-times) into the MSB-first WIDTH-bit words that drive the cascaded OSERDES2 master/slave pair. It runs in the fabric clock domain produced by oserdes_pll, sitting directly in front of the serializer `word` input.

## Interface
- WIDTH, 8: serializer word width in bits; MSB leaves the pin first.
- NREQ, 4: number of requesters.
- PW_BITS, 8: width of the requested pulse length field, in bits.
- GAP_WORDS, 2: forced all-zero words after each burst; 0 is legal.
- clock  in  1: fabric clock, the serializer CLKDIV.
- reset  in  1: asynchronous, active-low.
- enable  in  1: serializer usable (PLL locked and serdes reset released).
- req  in  NREQ: level requests; req[i] held until ack[i].
- pulse_width  in  NREQ*PW_BITS: per-requester length in bit-times; slice i must be stable while req[i] is high.
- ack  out  NREQ: one-hot, one-cycle grant/accept strobe.
- word  out  WIDTH: registered word to the serializer.
- busy  out  1: high in EMIT or GAP.
- owner  out  $clog2(NREQ): index of the last granted requester.
- pulse_count  out  16: completed non-zero bursts; wraps at 2^16.
- abort_count  out  8: bursts truncated by enable; saturates at 255.

## Operation
- FSM states are IDLE, EMIT, and GAP. All outputs reset to 0. The round-robin pointer resets so requester 0 has first priority.
- IDLE: `word` is 0. If `enable` is high and any `req` is set, the block picks the first requesting index after `owner` (cyclic) and latches `remaining = pulse_width[i]`.
- Grant with W ≠ 0: next state is EMIT. In the same registered cycle it asserts `ack[i]`, updates `owner`, and outputs the first word.
- Grant with W = 0: it asserts `ack[i]`, updates `owner`, and stays in IDLE. There is no word, no gap, and `pulse_count` does not change.
- EMIT while remaining > WIDTH: `word` is all ones and remaining decrements by WIDTH.
- EMIT while remaining ≤ WIDTH: `word` = ~({WIDTH{1}} >> remaining), a thermometer code with the top `remaining` bits set. `pulse_count` increments. The next state is GAP, or IDLE when GAP_WORDS = 0.
- GAP: `word` is 0 for GAP_WORDS cycles, then the FSM returns to IDLE.
- `enable` low while in EMIT: the next `word` is 0, the FSM goes to IDLE with no gap, and `abort_count` increments. `pulse_count` is unchanged.
- `enable` low while in GAP: the gap completes normally.
- `enable` low while in IDLE: no grant is issued.
- Requests that arrive during EMIT or GAP are held off until IDLE. `req` is not sampled outside IDLE.
- Arithmetic: `remaining` is PW_BITS wide and its subtraction never underflows. Burst length is ceil(W/WIDTH) words.

## Timing
- A request seen in IDLE at edge t produces `ack` and the first word at t+1.
- Minimum period between successive grants is ceil(W/WIDTH) + GAP_WORDS + 1 cycles; the +1 is the IDLE cycle.
- For W = 0, successive grants are 1 cycle apart.
- `busy` is high exactly while `word` belongs to EMIT or GAP.
- Asserting `reset` at any time clears `word` combinationally with the flop reset. No partial word persists.

## Structure
- Package oserdes_sched_pkg holds:
  - the state enum {IDLE, EMIT, GAP};
  - a thermometer function `therm_msb(n, WIDTH)`;
  - the default constants for WIDTH and GAP_WORDS.
- Sub-module rr_arbiter (parameter NREQ) takes `req` and `last` and returns a one-hot `gnt` and `index`. It is purely combinational; the pointer register lives in the parent.

## Test plan
- WIDTH=8, GAP_WORDS=2: req[0] with W=3 → ack[0] at t+1 with word 8'hE0, then two words of 8'h00, then IDLE. pulse_count becomes 1.
- W=20 on req[1] → words 8'hFF, 8'hFF, 8'hF0 on consecutive cycles. busy is high for 5 cycles.
- req = 4'b1111 held, each dropped after its ack → grants in order 0, 1, 2, 3. Then req = 4'b0101 with owner=3 → grants 0 then 2.
- W=0 on req[2] → single ack[2] pulse. word stays 0, busy stays 0, pulse_count is unchanged.
- W=40 started, enable dropped after the 2nd word → 3rd word is 8'h00, FSM is IDLE the next cycle, abort_count=1, pulse_count is unchanged.
- reset asserted mid-EMIT, then released → word, ack, busy, and counters are all 0. A fresh request is granted to requester 0 first.
